// File: rtl/time_ascii_sender.sv
// -----------------------------------------------------------------------------
// time_ascii_sender
//
// Purpose
//   Turns the current watch time (BCD digits from the digit splitter) into the
//   ASCII line "HH:MM:SS\r\n" and writes it one byte per cycle into the UART TX
//   FIFO. A frame is started by a one-cycle trigger (tick_1s or a PC request)
//   while sending is enabled. All digits are captured when the frame starts, so
//   the time cannot change halfway through a line.
//
// Optional feature (compile-time macro DHT_APPEND_EN)
//   When DHT_APPEND_EN is defined, the line becomes "HH:MM:SS T<tt> H<hh>\r\n".
//   tt and hh are the captured DHT temperature and humidity, limited to 99 and
//   printed as two decimal digits. Without the macro the DHT inputs are ignored.
//
// Parameters
//   SEP_CHAR : byte placed between HH, MM and SS (default ':')
//   CRLF     : 1 = line ends in 0x0D 0x0A, 0 = line ends in 0x0A only
//
// Ports
//   clk            in   system clock
//   rst            in   asynchronous reset, active low
//   i_trig         in   one-cycle send request
//   i_enable       in   sending allowed; only looked at while idle
//   hour1..sec0    in   BCD time digits (tens/ones of hour, minute, second)
//   temp_integral  in   DHT temperature, binary (DHT_APPEND_EN only)
//   humi_integral  in   DHT humidity, binary (DHT_APPEND_EN only)
//   i_full         in   TX FIFO full
//   o_push         out  FIFO write enable; the byte is written on the edge where it is 1
//   o_data         out  byte to write; valid whenever o_busy = 1
//   o_busy         out  a frame is being sent
//   o_drop         out  one-cycle pulse: a trigger arrived while a frame was in progress
// -----------------------------------------------------------------------------
module time_ascii_sender #(
    parameter logic [7:0]  SEP_CHAR = 8'h3A,
    parameter int unsigned CRLF     = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_trig,
    input  logic       i_enable,
    input  logic [3:0] hour1,
    input  logic [3:0] hour0,
    input  logic [3:0] min1,
    input  logic [3:0] min0,
    input  logic [3:0] sec1,
    input  logic [3:0] sec0,
    input  logic [7:0] temp_integral,
    input  logic [7:0] humi_integral,
    input  logic       i_full,
    output logic       o_push,
    output logic [7:0] o_data,
    output logic       o_busy,
    output logic       o_drop
);

    // FSM states
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    // Number of payload bytes in front of the line terminator.
`ifdef DHT_APPEND_EN
    localparam logic [4:0] BODY_LEN = 5'd16;
`else
    localparam logic [4:0] BODY_LEN = 5'd8;
`endif

    // The final 0x0A sits one position further out when a 0x0D precedes it.
    localparam logic [4:0] CR_LEN   = (CRLF != 0) ? 5'd1 : 5'd0;
    localparam logic [4:0] LAST_IDX = BODY_LEN + CR_LEN;

    // One BCD digit as ASCII; anything that is not a decimal digit prints as '?'.
    function automatic logic [7:0] f_digit_ascii(input logic [3:0] d);
        logic [7:0] ch;
        if (d <= 4'd9) begin
            ch = {4'h3, d};
        end else begin
            ch = 8'h3F;
        end
        return ch;
    endfunction

    logic [0:0] r_state;
    logic [4:0] r_idx;
    logic [3:0] r_h1;
    logic [3:0] r_h0;
    logic [3:0] r_m1;
    logic [3:0] r_m0;
    logic [3:0] r_s1;
    logic [3:0] r_s0;
    logic       r_drop;
    logic       w_send;
    logic       w_push;
    logic       w_start;
    logic       w_last;
    logic [7:0] w_byte;

`ifdef DHT_APPEND_EN
    // Limit a binary reading to the two decimal digits the line has room for.
    function automatic logic [7:0] f_sat99(input logic [7:0] v);
        logic [7:0] s;
        if (v > 8'd99) begin
            s = 8'd99;
        end else begin
            s = v;
        end
        return s;
    endfunction

    logic [7:0] r_temp;
    logic [7:0] r_humi;
`else
    // The DHT readings have no place in the short line.
    logic w_unused_dht;
    assign w_unused_dht = ^{temp_integral, humi_integral};
`endif

    assign w_send  = (r_state == ST_SEND);
    assign w_push  = w_send && !i_full;
    assign w_start = (r_state == ST_IDLE) && i_trig && i_enable;
    assign w_last  = (r_idx == LAST_IDX);

    // Byte selected by the current index from the captured digits.
    always_comb begin
        w_byte = 8'h00;
        case (r_idx)
            5'd0:       w_byte = f_digit_ascii(r_h1);
            5'd1:       w_byte = f_digit_ascii(r_h0);
            5'd2, 5'd5: w_byte = SEP_CHAR;
            5'd3:       w_byte = f_digit_ascii(r_m1);
            5'd4:       w_byte = f_digit_ascii(r_m0);
            5'd6:       w_byte = f_digit_ascii(r_s1);
            5'd7:       w_byte = f_digit_ascii(r_s0);
`ifdef DHT_APPEND_EN
            5'd8:       w_byte = 8'h20;
            5'd9:       w_byte = 8'h54;
            5'd10:      w_byte = 8'h30 + (r_temp / 8'd10);
            5'd11:      w_byte = 8'h30 + (r_temp % 8'd10);
            5'd12:      w_byte = 8'h20;
            5'd13:      w_byte = 8'h48;
            5'd14:      w_byte = 8'h30 + (r_humi / 8'd10);
            5'd15:      w_byte = 8'h30 + (r_humi % 8'd10);
`endif
            // Everything past the body is the terminator: 0x0A last, 0x0D before it.
            default: begin
                if (w_last) begin
                    w_byte = 8'h0A;
                end else begin
                    w_byte = 8'h0D;
                end
            end
        endcase
    end

    // Frame sequencer: start on an enabled trigger, advance on every accepted push.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_idx   <= 5'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state <= ST_SEND;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                    r_idx <= 5'd0;
                end
                ST_SEND: begin
                    if (w_push && w_last) begin
                        r_state <= ST_IDLE;
                        r_idx   <= 5'd0;
                    end else if (w_push) begin
                        r_idx   <= r_idx + 5'd1;
                    end else begin
                        r_idx   <= r_idx;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_idx   <= 5'd0;
                end
            endcase
        end
    end

    // Digit capture at frame start so the line reflects a single instant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_h1 <= 4'd0;
            r_h0 <= 4'd0;
            r_m1 <= 4'd0;
            r_m0 <= 4'd0;
            r_s1 <= 4'd0;
            r_s0 <= 4'd0;
        end else if (w_start) begin
            r_h1 <= hour1;
            r_h0 <= hour0;
            r_m1 <= min1;
            r_m0 <= min0;
            r_s1 <= sec1;
            r_s0 <= sec0;
        end else begin
            r_h1 <= r_h1;
            r_h0 <= r_h0;
            r_m1 <= r_m1;
            r_m0 <= r_m0;
            r_s1 <= r_s1;
            r_s0 <= r_s0;
        end
    end

`ifdef DHT_APPEND_EN
    // DHT capture at frame start, already limited to 99.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_temp <= 8'd0;
            r_humi <= 8'd0;
        end else if (w_start) begin
            r_temp <= f_sat99(temp_integral);
            r_humi <= f_sat99(humi_integral);
        end else begin
            r_temp <= r_temp;
            r_humi <= r_humi;
        end
    end
`endif

    // Rejected-trigger pulse; includes the edge that pushes the last byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_drop <= 1'b0;
        end else begin
            r_drop <= i_trig && w_send;
        end
    end

    // o_push must follow i_full in the same cycle, so it is decoded from state.
    assign o_push = w_push;
    assign o_busy = w_send;
    assign o_data = w_send ? w_byte : 8'h00;
    assign o_drop = r_drop;

endmodule

// File: tb/tb_time_ascii_sender.sv
// -----------------------------------------------------------------------------
// tb_time_ascii_sender
//   Self-checking bench for time_ascii_sender. A transaction-level model keeps
//   the expected line as a byte queue built from the formatting rules; each
//   cycle the DUT outputs are compared with the model. Directed scenarios cover
//   the documented cases, followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_time_ascii_sender;

`ifdef DHT_APPEND_EN
    localparam int N_FRAME = 18;
`else
    localparam int N_FRAME = 10;
`endif

    logic       clk;
    logic       rst;
    logic       i_trig;
    logic       i_enable;
    logic [3:0] hour1, hour0, min1, min0, sec1, sec0;
    logic [7:0] temp_integral, humi_integral;
    logic       i_full;
    logic       o_push;
    logic [7:0] o_data;
    logic       o_busy;
    logic       o_drop;

    time_ascii_sender dut (
        .clk           (clk),
        .rst           (rst),
        .i_trig        (i_trig),
        .i_enable      (i_enable),
        .hour1         (hour1),
        .hour0         (hour0),
        .min1          (min1),
        .min0          (min0),
        .sec1          (sec1),
        .sec0          (sec0),
        .temp_integral (temp_integral),
        .humi_integral (humi_integral),
        .i_full        (i_full),
        .o_push        (o_push),
        .o_data        (o_data),
        .o_busy        (o_busy),
        .o_drop        (o_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state
    logic [7:0] m_q[$];
    logic       m_busy = 1'b0;
    logic       m_drop = 1'b0;

    // Observation log for directed scenarios
    logic [7:0] log_q[$];
    int         busy_cnt;
    int         drop_cnt;
    logic [7:0] last_data;
    logic       last_drop;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] asc(input logic [3:0] d);
        if (d > 4'd9) return 8'h3F;
        else return 8'h30 + {4'h0, d};
    endfunction

    // Expected line from the current inputs.
    function automatic void build_frame();
        m_q = {};
        m_q.push_back(asc(hour1));
        m_q.push_back(asc(hour0));
        m_q.push_back(8'h3A);
        m_q.push_back(asc(min1));
        m_q.push_back(asc(min0));
        m_q.push_back(8'h3A);
        m_q.push_back(asc(sec1));
        m_q.push_back(asc(sec0));
`ifdef DHT_APPEND_EN
        begin
            int t, h;
            t = (temp_integral > 8'd99) ? 99 : int'(temp_integral);
            h = (humi_integral > 8'd99) ? 99 : int'(humi_integral);
            m_q.push_back(8'h20);
            m_q.push_back(8'h54);
            m_q.push_back(8'(48 + t / 10));
            m_q.push_back(8'(48 + t % 10));
            m_q.push_back(8'h20);
            m_q.push_back(8'h48);
            m_q.push_back(8'(48 + h / 10));
            m_q.push_back(8'(48 + h % 10));
        end
`endif
        m_q.push_back(8'h0D);
        m_q.push_back(8'h0A);
    endfunction

    task automatic clear_log();
        log_q    = {};
        busy_cnt = 0;
        drop_cnt = 0;
    endtask

    task automatic set_time(input logic [3:0] a, b, c, d, e, f);
        hour1 = a; hour0 = b; min1 = c; min0 = d; sec1 = e; sec0 = f;
    endtask

    // One clock cycle: starts and ends at a falling edge.
    task automatic step(input logic trig, input logic en, input logic full);
        i_trig = trig; i_enable = en; i_full = full;
        #1;
        check_eq("busy", o_busy, m_busy);
        check_eq("push", o_push, m_busy && !full);
        check_eq("drop", o_drop, m_drop);
        if (m_busy && m_q.size() > 0) check_eq("data", o_data, m_q[0]);
        if (o_push) log_q.push_back(o_data);
        if (o_busy) busy_cnt++;
        if (o_drop) drop_cnt++;
        last_data = o_data;
        last_drop = o_drop;
        @(posedge clk);
        m_drop = trig && m_busy;
        if (m_busy) begin
            if (!full) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) m_busy = 1'b0;
            end
        end else if (trig && en) begin
            build_frame();
            m_busy = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        i_trig = 1'b0;
        rst = 1'b0;
        #1;
        check_eq("rst_push", o_push, 1'b0);
        check_eq("rst_busy", o_busy, 1'b0);
        check_eq("rst_data", o_data, 8'h00);
        check_eq("rst_drop", o_drop, 1'b0);
        m_q = {};
        m_busy = 1'b0;
        m_drop = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    logic [7:0] exp2 [10];
    logic [7:0] exp6 [11];

    initial begin
        exp2 = '{8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h3A, 8'h35, 8'h36, 8'h0D, 8'h0A};
        exp6 = '{8'h36, 8'h20, 8'h54, 8'h32, 8'h35, 8'h20, 8'h48, 8'h39, 8'h39, 8'h0D, 8'h0A};
        rst = 1'b0; i_trig = 1'b0; i_enable = 1'b0; i_full = 1'b0;
        temp_integral = 8'd0; humi_integral = 8'd0;
        set_time(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        @(negedge clk);
        do_reset();

        // Basic line 12:34:56
        set_time(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        clear_log();
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < N_FRAME + 2; i++) step(1'b0, 1'b1, 1'b0);
        check_eq("t2_len", log_q.size(), N_FRAME);
        check_eq("t2_busy", busy_cnt, N_FRAME);
`ifndef DHT_APPEND_EN
        for (int i = 0; i < 10; i++)
            if (i < log_q.size()) check_eq($sformatf("t2_b%0d", i), log_q[i], exp2[i]);
`endif

        // Three-cycle stall after the 4th push
        clear_log();
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1);
        check_eq("t3_hold", last_data, 8'h34);
        check_eq("t3_nopush", log_q.size(), 4);
        for (int i = 0; i < N_FRAME - 4 + 2; i++) step(1'b0, 1'b1, 1'b0);
        check_eq("t3_busy", busy_cnt, N_FRAME + 3);
        check_eq("t3_len", log_q.size(), N_FRAME);
`ifndef DHT_APPEND_EN
        for (int i = 0; i < 10; i++)
            if (i < log_q.size()) check_eq($sformatf("t3_b%0d", i), log_q[i], exp2[i]);
`endif

        // Retrigger inside a frame
        clear_log();
        step(1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check_eq("t4_drop6", last_drop, 1'b1);
        for (int i = 0; i < N_FRAME + 4; i++) step(1'b0, 1'b1, 1'b0);
        check_eq("t4_len", log_q.size(), N_FRAME);
        check_eq("t4_drops", drop_cnt, 1);

        // Invalid digit, then a disabled trigger
        set_time(4'd1, 4'hA, 4'd3, 4'd4, 4'd5, 4'd6);
        clear_log();
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < N_FRAME + 1; i++) step(1'b0, 1'b1, 1'b0);
        check_eq("t5_len", log_q.size(), N_FRAME);
        if (log_q.size() > 1) check_eq("t5_qmark", log_q[1], 8'h3F);
        clear_log();
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
        check_eq("t5_dis_push", log_q.size(), 0);
        check_eq("t5_dis_drop", drop_cnt, 0);
        check_eq("t5_dis_busy", busy_cnt, 0);

        // Reset mid-frame, then a full frame from byte 0
        set_time(4'd2, 4'd3, 4'd5, 4'd9, 4'd0, 4'd7);
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);
        do_reset();
        clear_log();
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < N_FRAME + 1; i++) step(1'b0, 1'b1, 1'b0);
        check_eq("t1_len", log_q.size(), N_FRAME);
        if (log_q.size() > 0) check_eq("t1_first", log_q[0], 8'h32);

`ifdef DHT_APPEND_EN
        // DHT append with saturation
        set_time(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        temp_integral = 8'd25; humi_integral = 8'd150;
        clear_log();
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < N_FRAME + 1; i++) step(1'b0, 1'b1, 1'b0);
        check_eq("t6_len", log_q.size(), 18);
        for (int i = 0; i < 11; i++)
            if (log_q.size() == 18) check_eq($sformatf("t6_b%0d", i), log_q[7 + i], exp6[i]);
`endif

        // Randomized run; digits change every cycle to exercise the capture
        for (int n = 0; n < 600; n++) begin
            set_time(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                     4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                     4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            temp_integral = 8'($urandom_range(0, 255));
            humi_integral = 8'($urandom_range(0, 255));
            if (n == 300) do_reset();
            step($urandom_range(0, 5) == 0, $urandom_range(0, 7) != 0,
                 $urandom_range(0, 3) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
